fpu_mem_requester: RTL and testbench
====================================

Name: fpu_mem_requester

Overview:
Memory request engine that sits directly downstream of the FPU controller's request interface.
- Consumes read/write request pulses with base addresses and a chunk width/height.
- Moves image chunks, one cache line at a time, between external memory and the two column buffers: fill port for reads, drain port for writes.
- Drives making_request back to the controller for the whole life of a request.

Parameters:
COL_WIDTH, 10, rows held in a column buffer; a read fills height+2 rows, a write drains height rows
MEM_BUFFER_WIDTH, 512, bytes per buffer row (maximum chunk width)
LINE_BYTES, 64, bytes per memory beat; must divide MEM_BUFFER_WIDTH

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
req_read  input  1  pulse or level: fetch chunk into the fill buffer
req_write  input  1  pulse or level: store chunk from the drain buffer
read_address  input  32  byte address of chunk row 0 (read)
write_address  input  32  byte address of result row 0 (write)
width  input  $clog2(MEM_BUFFER_WIDTH)+1  chunk width in bytes, 1..MEM_BUFFER_WIDTH
height  input  5  result rows, 1..COL_WIDTH-2
row_stride  input  19  byte distance between consecutive image rows
making_request  output  1  busy indication to the controller
mem_req  output  1  memory request valid
mem_we  output  1  1 = write beat
mem_addr  output  32  line address
mem_be  output  LINE_BYTES  write byte enables
mem_wdata  output  LINE_BYTES*8  write data
mem_ack  input  1  request accepted this cycle
mem_rvalid  input  1  read data returned
mem_rdata  input  LINE_BYTES*8  read data
fill_we  output  1  write one line into the fill buffer
fill_row  output  $clog2(COL_WIDTH)  fill row
fill_line  output  $clog2(MEM_BUFFER_WIDTH/LINE_BYTES)  line index within the row
fill_data  output  LINE_BYTES*8  = mem_rdata, registered
drain_re  output  1  read one line from the drain buffer
drain_row  output  $clog2(COL_WIDTH)  drain row
drain_line  output  $clog2(MEM_BUFFER_WIDTH/LINE_BYTES)  line index
drain_data  input  LINE_BYTES*8  valid exactly 1 cycle after drain_re

Behaviour:
- Reset: every output is 0, state is IDLE, all counters are 0.
- making_request is combinational: busy | req_read | req_write. The controller never sees a gap between its pulse and the busy indication.
- IDLE behaviour:
  - Samples req_read, req_write, both addresses, width, height and row_stride into registers. Later input changes are ignored.
  - Requests arriving while busy are ignored.
- States: IDLE, WR_FETCH, WR_ISSUE, RD_ISSUE, RD_WAIT, DONE.
- Request ordering:
  - Both requests set in the same cycle: the write is performed first, then the read.
  - Write only: enter WR_FETCH. Read only: enter RD_ISSUE.
- Line geometry:
  - lines = ceil(width/LINE_BYTES).
  - Row r, line l address = base + r*row_stride + l*LINE_BYTES, computed 32-bit and wrapping.
  - Rows run 0..H-1, with lines 0..lines-1 inside each row, row-major.
  - H = height for writes, H = height+2 for reads.
- WR_FETCH: pulse drain_re with the current row/line, then go to WR_ISSUE.
- WR_ISSUE:
  - mem_req=1, mem_we=1, mem_wdata=drain_data captured on entry.
  - mem_be is all ones, except on the last line of a row, where only the low (width - l*LINE_BYTES) bytes are enabled.
  - Held stable until mem_ack.
  - On ack: advance line/row. If more lines remain, go to WR_FETCH. Otherwise go to RD_ISSUE if a read is pending, else DONE.
- RD_ISSUE: mem_req=1, mem_we=0, held until mem_ack, then go to RD_WAIT. One read is outstanding at a time.
- RD_WAIT:
  - On mem_rvalid: fill_we=1 next cycle with the row/line of that beat, and fill_data=mem_rdata.
  - Advance, then go to RD_ISSUE, or DONE after the final line.
  - The full last line is read and written; bytes beyond width are don't-care.
- DONE: one cycle, busy=0 next cycle, return to IDLE. A new request is accepted in the cycle after DONE.
- mem_ack in the same cycle mem_req first rises is legal; that beat completes in one cycle.
- mem_rvalid outside RD_WAIT is ignored.
- Reset mid-operation aborts immediately: no partial completion, all outputs 0.

Optional Feature:
Macro FPU_MEMREQ_PERF_EN.
- Defined:
  - Adds output stall_cycles[31:0], which counts cycles where mem_req=1 and mem_ack=0, plus RD_WAIT cycles without mem_rvalid.
  - Adds output beats[31:0], which counts acked beats.
  - Both counters saturate at all ones, clear on reset, and never clear on a new request.
- Undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- Read only: width=512, height=8, read_address=0x1000_0000, row_stride=0x600, mem_ack same cycle, rvalid +2 cycles -> 80 beats. Addresses for row r are 0x1000_0000+r*0x600+{0..7}*64. fill rows 0..9, lines 0..7. making_request is high from the pulse cycle through DONE.
- Write only: width=100, height=2, write_address=0x2000_0000 -> 4 beats. Line 1 of each row has mem_be=0x0000_000F_FFFF_FFFF (36 bytes). wdata equals drain_data from 1 cycle after drain_re.
- Simultaneous read+write, width=64, height=1 -> 1 write beat first, then 3 read beats; making_request never drops between them.
- Backpressure: mem_ack held low 5 cycles -> mem_req, mem_addr, mem_wdata and mem_be stay stable. With FPU_MEMREQ_PERF_EN, stall_cycles increments by 5.
- Request while busy: second req_read mid-transfer -> ignored, and beat count is unchanged.
- Reset after beat 3 of a read -> all outputs 0 next edge. A subsequent request starts from row 0 line 0.

Source files
------------

// File: rtl/fpu_mem_requester.sv
// Moves image chunks, one cache line per beat, between external memory and the FPU column buffers.
// Optional `FPU_MEMREQ_PERF_EN adds saturating stall_cycles / beats counters.
module fpu_mem_requester #(
  parameter int COL_WIDTH        = 10,
  parameter int MEM_BUFFER_WIDTH = 512,
  parameter int LINE_BYTES       = 64,
  localparam int WW = $clog2(MEM_BUFFER_WIDTH) + 1,
  localparam int RW = $clog2(COL_WIDTH),
  localparam int LW = $clog2(MEM_BUFFER_WIDTH / LINE_BYTES),
  localparam int DW = LINE_BYTES * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_read,
  input  logic                  req_write,
  input  logic [31:0]           read_address,
  input  logic [31:0]           write_address,
  input  logic [WW-1:0]         width,
  input  logic [4:0]            height,
  input  logic [18:0]           row_stride,
  output logic                  making_request,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [LINE_BYTES-1:0] mem_be,
  output logic [DW-1:0]         mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_rvalid,
  input  logic [DW-1:0]         mem_rdata,
  output logic                  fill_we,
  output logic [RW-1:0]         fill_row,
  output logic [LW-1:0]         fill_line,
  output logic [DW-1:0]         fill_data,
  output logic                  drain_re,
  output logic [RW-1:0]         drain_row,
  output logic [LW-1:0]         drain_line,
  input  logic [DW-1:0]         drain_data,
`ifdef FPU_MEMREQ_PERF_EN
  output logic [31:0]           stall_cycles,
  output logic [31:0]           beats,
`endif
  output logic [2:0]            dbg_state_o
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] WR_FETCH = 3'd1;
  localparam logic [2:0] WR_ISSUE = 3'd2;
  localparam logic [2:0] RD_ISSUE = 3'd3;
  localparam logic [2:0] RD_WAIT  = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  logic [2:0]    state_q, state_d;
  logic          rd_pend_q, rd_pend_d;
  logic [31:0]   rd_addr_q, rd_addr_d;
  logic [WW-1:0] width_q, width_d;
  logic [4:0]    height_q, height_d;
  logic [18:0]   stride_q, stride_d;
  logic [RW-1:0] row_q, row_d;
  logic [LW-1:0] line_q, line_d;
  logic [31:0]   row_base_q, row_base_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          wr_first_q, wr_first_d;
  logic          fill_we_q, fill_we_d;
  logic [RW-1:0] fill_row_q, fill_row_d;
  logic [LW-1:0] fill_line_q, fill_line_d;
  logic [DW-1:0] fill_data_q, fill_data_d;

  logic                  rd_phase_c, last_line_c, last_row_c, done_all_c;
  logic [WW-1:0]         lines_m1_c, rem_c;
  logic [4:0]            h_m1_c;
  logic [LINE_BYTES-1:0] be_c;

  // Geometry of the current beat; reads cover two extra halo rows.
  always_comb begin
    rd_phase_c  = (state_q == RD_ISSUE) || (state_q == RD_WAIT);
    lines_m1_c  = (width_q - WW'(1)) / WW'(LINE_BYTES);
    h_m1_c      = rd_phase_c ? (height_q + 5'd1) : (height_q - 5'd1);
    last_line_c = (WW'(line_q) == lines_m1_c);
    last_row_c  = (5'(row_q) == h_m1_c);
    done_all_c  = last_line_c && last_row_c;
    rem_c       = width_q - WW'(line_q) * WW'(LINE_BYTES);
    be_c        = '0;
    for (int b = 0; b < LINE_BYTES; b++) be_c[b] = !last_line_c || (rem_c > WW'(b));
  end

  always_comb begin
    state_d     = state_q;
    rd_pend_d   = rd_pend_q;
    rd_addr_d   = rd_addr_q;
    width_d     = width_q;
    height_d    = height_q;
    stride_d    = stride_q;
    row_d       = row_q;
    line_d      = line_q;
    row_base_d  = row_base_q;
    wdata_d     = wdata_q;
    wr_first_d  = 1'b0;
    fill_we_d   = 1'b0;
    fill_row_d  = fill_row_q;
    fill_line_d = fill_line_q;
    fill_data_d = fill_data_q;
    case (state_q)
      IDLE: begin
        if (req_read || req_write) begin
          width_d   = width;
          height_d  = height;
          stride_d  = row_stride;
          rd_addr_d = read_address;
          row_d     = '0;
          line_d    = '0;
          if (req_write) begin
            state_d    = WR_FETCH;
            rd_pend_d  = req_read;
            row_base_d = write_address;
          end else begin
            state_d    = RD_ISSUE;
            rd_pend_d  = 1'b0;
            row_base_d = read_address;
          end
        end
      end
      WR_FETCH: begin
        state_d    = WR_ISSUE;
        wr_first_d = 1'b1;
      end
      WR_ISSUE: begin
        // drain_data is only valid in the first cycle; hold it for the rest of the beat.
        if (wr_first_q) wdata_d = drain_data;
        if (mem_ack) begin
          if (done_all_c) begin
            row_d  = '0;
            line_d = '0;
            if (rd_pend_q) begin
              state_d    = RD_ISSUE;
              rd_pend_d  = 1'b0;
              row_base_d = rd_addr_q;
            end else begin
              state_d = DONE;
            end
          end else begin
            state_d    = WR_FETCH;
            line_d     = last_line_c ? '0 : line_q + LW'(1);
            row_d      = last_line_c ? row_q + RW'(1) : row_q;
            row_base_d = last_line_c ? row_base_q + 32'(stride_q) : row_base_q;
          end
        end
      end
      RD_ISSUE: begin
        if (mem_ack) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (mem_rvalid) begin
          fill_we_d   = 1'b1;
          fill_row_d  = row_q;
          fill_line_d = line_q;
          fill_data_d = mem_rdata;
          if (done_all_c) begin
            state_d = DONE;
            row_d   = '0;
            line_d  = '0;
          end else begin
            state_d    = RD_ISSUE;
            line_d     = last_line_c ? '0 : line_q + LW'(1);
            row_d      = last_line_c ? row_q + RW'(1) : row_q;
            row_base_d = last_line_c ? row_base_q + 32'(stride_q) : row_base_q;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      width_q     <= '0;
      height_q    <= '0;
      stride_q    <= '0;
      row_q       <= '0;
      line_q      <= '0;
      row_base_q  <= '0;
      wdata_q     <= '0;
      wr_first_q  <= 1'b0;
      fill_we_q   <= 1'b0;
      fill_row_q  <= '0;
      fill_line_q <= '0;
      fill_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rd_pend_q   <= rd_pend_d;
      rd_addr_q   <= rd_addr_d;
      width_q     <= width_d;
      height_q    <= height_d;
      stride_q    <= stride_d;
      row_q       <= row_d;
      line_q      <= line_d;
      row_base_q  <= row_base_d;
      wdata_q     <= wdata_d;
      wr_first_q  <= wr_first_d;
      fill_we_q   <= fill_we_d;
      fill_row_q  <= fill_row_d;
      fill_line_q <= fill_line_d;
      fill_data_q <= fill_data_d;
    end
  end

  // Handshake: a beat is presented while mem_req=1 and retires in the cycle mem_ack=1;
  // all mem_* fields stay stable until then. drain_data answers drain_re one cycle later.
  always_comb begin
    making_request = (state_q != IDLE) || req_read || req_write;
    mem_req        = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    mem_we         = (state_q == WR_ISSUE);
    mem_addr       = mem_req ? (row_base_q + 32'(line_q) * 32'(LINE_BYTES)) : 32'd0;
    mem_be         = mem_we ? be_c : '0;
    mem_wdata      = mem_we ? (wr_first_q ? drain_data : wdata_q) : '0;
    drain_re       = (state_q == WR_FETCH);
    drain_row      = drain_re ? row_q : '0;
    drain_line     = drain_re ? line_q : '0;
    fill_we        = fill_we_q;
    fill_row       = fill_row_q;
    fill_line      = fill_line_q;
    fill_data      = fill_data_q;
    dbg_state_o    = state_q;
  end

`ifdef FPU_MEMREQ_PERF_EN
  logic [31:0] stall_q, beats_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      if (((mem_req && !mem_ack) || (state_q == RD_WAIT && !mem_rvalid)) && (stall_q != '1))
        stall_q <= stall_q + 32'd1;
      if (mem_req && mem_ack && (beats_q != '1))
        beats_q <= beats_q + 32'd1;
    end
  end
  assign stall_cycles = stall_q;
  assign beats        = beats_q;
`endif

endmodule

// File: tb/tb_fpu_mem_requester.sv
// Randomized bench for fpu_mem_requester: memory/drain responder, beat and fill scoreboards.
// Build with FPU_MEMREQ_PERF_EN defined to also check the perf counters.
module tb_fpu_mem_requester;
  localparam int DW = 512;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_read = 1'b0, req_write = 1'b0;
  logic [31:0] read_address = '0, write_address = '0;
  logic [9:0] width = '0;
  logic [4:0] height = '0;
  logic [18:0] row_stride = '0;
  logic making_request, mem_req, mem_we, fill_we, drain_re;
  logic [31:0] mem_addr;
  logic [63:0] mem_be;
  logic [DW-1:0] mem_wdata, fill_data;
  logic mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0, drain_data = '0;
  logic [3:0] fill_row, drain_row;
  logic [2:0] fill_line, drain_line;
  logic [2:0] dbg_state;
`ifdef FPU_MEMREQ_PERF_EN
  logic [31:0] stall_cycles, beats;
`endif

  fpu_mem_requester dut (
    .clk(clk), .rst_n(rst_n), .req_read(req_read), .req_write(req_write),
    .read_address(read_address), .write_address(write_address), .width(width),
    .height(height), .row_stride(row_stride), .making_request(making_request),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .fill_we(fill_we), .fill_row(fill_row), .fill_line(fill_line), .fill_data(fill_data),
    .drain_re(drain_re), .drain_row(drain_row), .drain_line(drain_line), .drain_data(drain_data),
`ifdef FPU_MEMREQ_PERF_EN
    .stall_cycles(stall_cycles), .beats(beats),
`endif
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct {logic we; logic [31:0] addr; logic [63:0] be; logic [DW-1:0] wdata;} beat_t;
  typedef struct {logic [3:0] row; logic [2:0] line; logic [DW-1:0] data;} fill_t;
  beat_t exp_beat_q[$];
  fill_t exp_fill_q[$];

  int pass_cnt = 0, total_cnt = 0;
  int ack_min = 0, ack_max = 0, rv_min = 1, rv_max = 1;
  bit spurious_en = 1'b0;
  int stall_model = 0, beat_model = 0, beats_seen = 0;
  logic [31:0] dsalt = 32'h1234_5678, rsalt = 32'h9abc_def0;

  function automatic logic [DW-1:0] drain_word(int r, int l);
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = dsalt ^ 32'(r * 256 + l) ^ 32'(i * 32'h0101_0101);
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_word(logic [31:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = a ^ rsalt ^ 32'(i * 32'h1000_0001);
    return v;
  endfunction

  // Reference: expected beat stream from the chunk geometry (writes first, then reads).
  task automatic build_model(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                             input int w, input int h, input int s);
    int lines, nb;
    beat_t b;
    fill_t f;
    exp_beat_q.delete();
    exp_fill_q.delete();
    lines = (w + 63) / 64;
    if (wr)
      for (int r = 0; r < h; r++)
        for (int l = 0; l < lines; l++) begin
          nb = w - l * 64;
          if (nb > 64) nb = 64;
          b.we = 1'b1;
          b.addr = wa + 32'(r * s) + 32'(l * 64);
          b.be = '0;
          for (int k = 0; k < nb; k++) b.be[k] = 1'b1;
          b.wdata = drain_word(r, l);
          exp_beat_q.push_back(b);
        end
    if (rd)
      for (int r = 0; r < h + 2; r++)
        for (int l = 0; l < lines; l++) begin
          b.we = 1'b0;
          b.addr = ra + 32'(r * s) + 32'(l * 64);
          b.be = '0;
          b.wdata = '0;
          exp_beat_q.push_back(b);
          f.row = 4'(r);
          f.line = 3'(l);
          f.data = mem_word(b.addr);
          exp_fill_q.push_back(f);
        end
  endtask

  // Memory + drain-buffer responder and scoreboard, evaluated each negedge.
  initial begin
    bit in_beat = 0, rv_pend = 0, drain_pend = 0;
    int ack_cnt = 0, rv_cnt = 0;
    logic [31:0] rv_addr = '0, s_addr = '0;
    logic s_we = 0;
    logic [63:0] s_be = '0;
    logic [DW-1:0] s_wdata = '0;
    logic [3:0] dr = '0;
    logic [2:0] dl = '0;
    beat_t e;
    fill_t f;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_ack = 0; mem_rvalid = 0; in_beat = 0; rv_pend = 0; drain_pend = 0;
        continue;
      end
      if (fill_we) begin
        total_cnt++;
        if (exp_fill_q.size() == 0) $display("FAIL fill_unexpected row=%0d line=%0d required none", fill_row, fill_line);
        else begin
          f = exp_fill_q.pop_front();
          if (fill_row !== f.row || fill_line !== f.line || fill_data !== f.data)
            $display("FAIL fill row/line got %0d/%0d data %h required %0d/%0d data %h",
                     fill_row, fill_line, fill_data[31:0], f.row, f.line, f.data[31:0]);
          else pass_cnt++;
        end
      end
      mem_rvalid = 0;
      if (rv_pend) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1; mem_rdata = mem_word(rv_addr); rv_pend = 0;
        end else stall_model++;
      end else if (spurious_en && mem_req && mem_we && $urandom_range(0, 1) == 1) begin
        mem_rvalid = 1; mem_rdata = {16{$urandom}};
      end
      mem_ack = 0;
      if (mem_req) begin
        if (!in_beat) begin
          in_beat = 1; ack_cnt = $urandom_range(ack_min, ack_max);
          s_addr = mem_addr; s_we = mem_we; s_be = mem_be; s_wdata = mem_wdata;
        end else begin
          total_cnt++;
          if (mem_addr !== s_addr || mem_we !== s_we || mem_be !== s_be || mem_wdata !== s_wdata)
            $display("FAIL stall_stability addr %h we %b be %h got vs held addr %h we %b be %h",
                     mem_addr, mem_we, mem_be, s_addr, s_we, s_be);
          else pass_cnt++;
        end
        if (ack_cnt == 0) begin
          mem_ack = 1; in_beat = 0; beat_model++; beats_seen++;
          total_cnt++;
          if (exp_beat_q.size() == 0) $display("FAIL beat_unexpected addr=%h required none", mem_addr);
          else begin
            e = exp_beat_q.pop_front();
            if (mem_we !== e.we || mem_addr !== e.addr ||
                (e.we && (mem_be !== e.be || mem_wdata !== e.wdata)))
              $display("FAIL beat we/addr/be got %b %h %h wdata %h required %b %h %h wdata %h",
                       mem_we, mem_addr, mem_be, mem_wdata[31:0], e.we, e.addr, e.be, e.wdata[31:0]);
            else pass_cnt++;
          end
          if (!mem_we) begin
            rv_pend = 1; rv_cnt = $urandom_range(rv_min, rv_max); rv_addr = mem_addr;
          end
        end else begin
          ack_cnt--; stall_model++;
        end
      end
      drain_pend = drain_re; dr = drain_row; dl = drain_line;
      @(posedge clk);
      #1;
      drain_data = drain_pend ? drain_word(int'(dr), int'(dl)) : {16{$urandom}};
    end
  end

  task automatic start_req(input bit rd, input bit wr, input logic [31:0] ra, input logic [31:0] wa,
                           input int w, input int h, input int s);
    build_model(rd, wr, ra, wa, w, h, s);
    @(negedge clk); #2;
    req_read = rd; req_write = wr; read_address = ra; write_address = wa;
    width = 10'(w); height = 5'(h); row_stride = 19'(s);
    #1;
  endtask

  task automatic release_req();
    @(negedge clk); #2;
    req_read = 0; req_write = 0;
    read_address = $urandom; write_address = $urandom;
    width = 10'($urandom_range(1, 512)); height = 5'($urandom_range(1, 8)); row_stride = 19'($urandom);
  endtask

  task automatic wait_idle(input int budget, output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (!making_request) begin timed_out = 0; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    #12;
    total_cnt++;
    if ({making_request, mem_req, mem_we, mem_addr, mem_be} !== '0)
      $display("FAIL reset_mem got req=%b we=%b addr=%h be=%h required 0", mem_req, mem_we, mem_addr, mem_be);
    else pass_cnt++;
    total_cnt++;
    if ({mem_wdata, fill_we, fill_row, fill_line, fill_data, drain_re, drain_row, drain_line} !== '0)
      $display("FAIL reset_buf got fill_we=%b drain_re=%b required 0", fill_we, drain_re);
    else pass_cnt++;
    total_cnt++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state got %0d required 0", dbg_state);
    else pass_cnt++;
    @(negedge clk); rst_n = 1;
  endtask

  task automatic check_done(input string name, input bit to, input int b0, input int nbeats);
    total_cnt++;
    if (to || exp_beat_q.size() != 0 || exp_fill_q.size() != 0 || beats_seen - b0 != nbeats)
      $display("FAIL %s timeout=%b left beats=%0d fills=%0d seen=%0d required 0/0/0/%0d",
               name, to, exp_beat_q.size(), exp_fill_q.size(), beats_seen - b0, nbeats);
    else pass_cnt++;
`ifdef FPU_MEMREQ_PERF_EN
    total_cnt++;
    if (stall_cycles !== 32'(stall_model) || beats !== 32'(beat_model))
      $display("FAIL %s_perf got stall=%0d beats=%0d required %0d %0d", name, stall_cycles, beats, stall_model, beat_model);
    else pass_cnt++;
`endif
  endtask

  task automatic test_read_only();
    bit to; int b0 = beats_seen;
    ack_min = 0; ack_max = 0; rv_min = 2; rv_max = 2; spurious_en = 0;
    start_req(1, 0, 32'h1000_0000, 32'h0, 512, 8, 32'h600);
    total_cnt++;
    if (making_request !== 1'b1) $display("FAIL read_pulse_busy got %b required 1", making_request);
    else pass_cnt++;
    release_req();
    wait_idle(2000, to);
    check_done("read_only", to, b0, 80);
  endtask

  task automatic test_write_only();
    bit to; int b0 = beats_seen;
    ack_min = 0; ack_max = 2; rv_min = 1; rv_max = 3; spurious_en = 1;
    start_req(0, 1, 32'h0, 32'h2000_0000, 100, 2, 32'h400);
    release_req();
    wait_idle(500, to);
    check_done("write_only", to, b0, 4);
  endtask

  task automatic test_both();
    bit to; int b0 = beats_seen;
    ack_min = 0; ack_max = 1; rv_min = 1; rv_max = 3; spurious_en = 1;
    start_req(1, 1, 32'h3000_0040, 32'h4000_0000, 64, 1, 32'h200);
    release_req();
    wait_idle(500, to);
    check_done("read_write", to, b0, 4);
  endtask

  task automatic test_backpressure();
    bit to; int b0 = beats_seen;
`ifdef FPU_MEMREQ_PERF_EN
    logic [31:0] st0 = stall_cycles;
`endif
    ack_min = 5; ack_max = 5; spurious_en = 0;
    start_req(0, 1, 32'h0, 32'h5000_0000, 64, 1, 32'h100);
    release_req();
    wait_idle(200, to);
    check_done("backpressure", to, b0, 1);
`ifdef FPU_MEMREQ_PERF_EN
    total_cnt++;
    if (stall_cycles - st0 !== 32'd5) $display("FAIL bp_stall_delta got %0d required 5", stall_cycles - st0);
    else pass_cnt++;
`endif
  endtask

  task automatic test_busy_ignored();
    bit to; int b0 = beats_seen;
    ack_min = 0; ack_max = 2; rv_min = 1; rv_max = 2; spurious_en = 0;
    start_req(1, 0, 32'h6000_0000, 32'h0, 192, 3, 32'h1000);
    release_req();
    for (int i = 0; i < 200 && beats_seen < b0 + 4; i++) @(negedge clk);
    #2; req_read = 1; req_write = 1; read_address = 32'h7777_0000; write_address = 32'h8888_0000;
    @(negedge clk); #2; req_read = 0; req_write = 0;
    wait_idle(1000, to);
    check_done("busy_ignored", to, b0, 15);
  endtask

  task automatic test_reset_mid_read();
    bit to; int b0 = beats_seen;
    ack_min = 0; ack_max = 1; rv_min = 1; rv_max = 2; spurious_en = 0;
    start_req(1, 0, 32'h0900_0000, 32'h0, 256, 4, 32'h800);
    release_req();
    for (int i = 0; i < 200 && beats_seen < b0 + 3; i++) @(negedge clk);
    @(posedge clk); #2; rst_n = 0; #1;
    total_cnt++;
    if ({making_request, mem_req, mem_we, mem_addr, mem_be, mem_wdata, fill_we, fill_row, fill_line,
         fill_data, drain_re, drain_row, drain_line} !== '0)
      $display("FAIL reset_mid_read got req=%b addr=%h fill_we=%b required 0", mem_req, mem_addr, fill_we);
    else pass_cnt++;
    exp_beat_q.delete(); exp_fill_q.delete();
    stall_model = 0; beat_model = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    b0 = beats_seen;
    start_req(1, 0, 32'h0A00_0000, 32'h0, 64, 1, 32'h40);
    release_req();
    wait_idle(300, to);
    check_done("after_reset", to, b0, 3);
  endtask

  task automatic test_random();
    bit to, rd, wr; int b0, w, h, s, lines, n;
    logic [31:0] ra, wa;
    ack_min = 0; ack_max = 3; rv_min = 1; rv_max = 3; spurious_en = 1;
    for (int t = 0; t < 6; t++) begin
      dsalt = $urandom; rsalt = $urandom;
      wr = 1'($urandom_range(0, 1)); rd = wr ? 1'($urandom_range(0, 1)) : 1'b1;
      w = $urandom_range(1, 512); h = $urandom_range(1, 8); s = $urandom_range(0, 19'h7FFFF);
      ra = (t == 2) ? 32'hFFFF_FF80 : $urandom; wa = $urandom;
      lines = (w + 63) / 64;
      n = (wr ? h * lines : 0) + (rd ? (h + 2) * lines : 0);
      b0 = beats_seen;
      start_req(rd, wr, ra, wa, w, h, s);
      release_req();
      wait_idle(8000, to);
      check_done("random", to, b0, n);
    end
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_write_only();
    test_both();
    test_backpressure();
    test_busy_ignored();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
